// File: rtl/lc3_mem_loader.sv
// lc3_mem_loader: boot-time loader that writes a big-endian LC-3 object image into memory
// and holds the core in reset until the image is fully written.
module lc3_mem_loader #(
    parameter int WORDCOUNT = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_i,
    input  logic        in_valid_i,
    input  logic [7:0]  in_data_i,
    input  logic        in_last_i,
    output logic        in_ready_o,
    output logic        mem_we_o,
    output logic [15:0] mem_addr_o,
    output logic [15:0] mem_wdata_o,
    output logic        core_reset_n_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [15:0] word_count_o
);
    typedef enum logic [2:0] {IDLE, ORIG_HI, ORIG_LO, DATA_HI, DATA_LO, WRITE, DONE, ERROR} state_t;
    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d, word_q, word_d, count_q, count_d;
    logic        last_q, last_d;
    logic        accept, in_range;
    assign accept   = in_valid_i && in_ready_o;
    assign in_range = {16'd0, addr_q} < 32'(WORDCOUNT);
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            word_q  <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end
    // The origin high byte is parked in word_q until the low byte completes the address.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        word_d  = word_q;
        count_d = count_q;
        last_d  = last_q;
        case (state_q)
            IDLE: state_d = start_i ? ORIG_HI : IDLE;
            ORIG_HI: if (accept) begin
                word_d[15:8] = in_data_i;
                state_d      = in_last_i ? ERROR : ORIG_LO;
            end
            ORIG_LO: if (accept) begin
                addr_d  = {word_q[15:8], in_data_i};
                state_d = in_last_i ? DONE : DATA_HI;
            end
            DATA_HI: if (accept) begin
                word_d[15:8] = in_data_i;
                state_d      = in_last_i ? ERROR : DATA_LO;
            end
            DATA_LO: if (accept) begin
                word_d[7:0] = in_data_i;
                last_d      = in_last_i;
                state_d     = WRITE;
            end
            WRITE: if (in_range) begin
                count_d = count_q + 16'd1;
                addr_d  = addr_q + 16'd1;
                state_d = last_q ? DONE : DATA_HI;
            end else begin
                state_d = ERROR;
            end
            DONE, ERROR: if (start_i) begin
                count_d = '0;
                state_d = ORIG_HI;
            end
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        in_ready_o     = state_q inside {ORIG_HI, ORIG_LO, DATA_HI, DATA_LO};
        mem_we_o       = (state_q == WRITE) && in_range;
        mem_addr_o     = addr_q;
        mem_wdata_o    = word_q;
        core_reset_n_o = state_q == DONE;
        busy_o         = !(state_q inside {IDLE, DONE, ERROR});
        done_o         = state_q == DONE;
        error_o        = state_q == ERROR;
        word_count_o   = count_q;
    end
endmodule
